// File: rtl/clock_step_controller_pkg.sv
// clock_step_controller_pkg: shared state encoding and speed-to-tap mapping for the bus clock controller
package clock_step_controller_pkg;

    typedef enum logic [1:0] {ST_LOW, ST_HIGH, ST_HALTED} state_t;

    // Higher speed_sel selects a lower prescaler tap, clamped at tap 0 (strobe every cycle)
    function automatic int tap_for(int div_width, int speed_sel);
        return (div_width - 1 - speed_sel) > 0 ? div_width - 1 - speed_sel : 0;
    endfunction

endpackage

// File: rtl/clock_step_controller_button_debouncer.sv
// button_debouncer: synchronises a raw button, debounces it and emits one pulse per debounced press
module button_debouncer #(
    parameter int WIDTH = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    logic [1:0]       sync;
    logic [WIDTH-1:0] cnt;
    logic             stable;

    // The synchronised input must differ from the stable level for 2^WIDTH samples in a row to flip it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync   <= '0;
            cnt    <= '0;
            stable <= 1'b0;
            press  <= 1'b0;
        end else begin
            sync  <= {sync[0], btn};
            press <= 1'b0;
            if (sync[1] == stable) begin
                cnt <= '0;
            end else if (&cnt) begin
                stable <= sync[1];
                press  <= sync[1];
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/clock_step_controller.sv
// clock_step_controller: bus/control clock-enable strobes from a free-running prescaler,
// with selectable speed, debounced single-step and a latched halt
module clock_step_controller
    import clock_step_controller_pkg::*;
#(
    parameter int DIV_WIDTH      = 22,
    parameter int SPEED_BITS     = 3,
    parameter int DEBOUNCE_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SPEED_BITS-1:0] speed_sel,
    input  logic                  step_mode,
    input  logic                  step_btn,
    input  logic                  hlt,
    output logic                  bus_tick,
    output logic                  control_tick,
    output logic                  bus_level,
    output logic                  halted
);

    localparam int TAP_W = DIV_WIDTH > 1 ? $clog2(DIV_WIDTH) : 1;

    state_t               state;
    logic [DIV_WIDTH-1:0] cnt;
    logic [TAP_W-1:0]     tap;
    logic                 pending;
    logic                 halt_req;
    logic                 step_press;
    logic [DIV_WIDTH-1:0] mask;
    logic                 strobe;

    assign mask   = ~({DIV_WIDTH{1'b1}} << tap);
    assign strobe = (cnt & mask) == mask;

    button_debouncer #(.WIDTH(DEBOUNCE_WIDTH)) u_step (
        .clk   (clk),
        .rst   (rst),
        .btn   (step_btn),
        .press (step_press)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_LOW;
            cnt          <= '0;
            tap          <= TAP_W'(DIV_WIDTH - 1);
            pending      <= 1'b0;
            halt_req     <= 1'b0;
            bus_tick     <= 1'b0;
            control_tick <= 1'b0;
            bus_level    <= 1'b0;
            halted       <= 1'b0;
        end else begin
            cnt          <= cnt + 1'b1;
            bus_tick     <= 1'b0;
            control_tick <= 1'b0;
            // Speed changes only take effect at a low-phase strobe, so a high phase is never cut short
            if (strobe && !bus_level)
                tap <= TAP_W'(tap_for(DIV_WIDTH, int'(speed_sel)));
            case (state)
                ST_LOW: begin
                    if (hlt) begin
                        state  <= ST_HALTED;
                        halted <= 1'b1;
                    end else if (strobe && (!step_mode || pending)) begin
                        state     <= ST_HIGH;
                        bus_level <= 1'b1;
                        bus_tick  <= 1'b1;
                        pending   <= 1'b0;
                    end else begin
                        pending <= step_mode && (pending || step_press);
                    end
                end
                ST_HIGH: begin
                    halt_req <= halt_req || hlt;
                    if (strobe) begin
                        state        <= (halt_req || hlt) ? ST_HALTED : ST_LOW;
                        halted       <= halt_req || hlt;
                        bus_level    <= 1'b0;
                        control_tick <= 1'b1;
                        halt_req     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_clock_step_controller.sv
// tb_clock_step_controller: randomized run/step/halt/reset stimulus checked cycle by cycle against a behavioural model
module tb_clock_step_controller;

    localparam int DW  = 4;
    localparam int SB  = 2;
    localparam int DB  = 2;
    localparam int NDB = 1 << DB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [SB-1:0] speed_sel = '0;
    logic          step_mode = 1'b0;
    logic          step_btn = 1'b0;
    logic          hlt = 1'b0;
    logic          bus_tick, control_tick, bus_level, halted;

    int checks = 0;
    int fails  = 0;

    // Model state: prescaler as an edge count, bus phase, halt, one pending press, raw button history
    int n, tap_m;
    bit m_high, m_halt, m_pend, m_hreq, m_db, m_press, e_bt, e_ct;
    bit hist[$];

    clock_step_controller #(
        .DIV_WIDTH      (DW),
        .SPEED_BITS     (SB),
        .DEBOUNCE_WIDTH (DB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .speed_sel    (speed_sel),
        .step_mode    (step_mode),
        .step_btn     (step_btn),
        .hlt          (hlt),
        .bus_tick     (bus_tick),
        .control_tick (control_tick),
        .bus_level    (bus_level),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        n = 0;
        tap_m = DW - 1;
        m_high = 0; m_halt = 0; m_pend = 0; m_hreq = 0;
        m_db = 0; m_press = 0; e_bt = 0; e_ct = 0;
        hist.delete();
        for (int i = 0; i < NDB + 2; i++) hist.push_back(1'b0);
    endtask

    task automatic model_step();
        int  period;
        bit  strobe, all_diff;
        period = 1 << tap_m;
        strobe = (n % period) == period - 1;
        n++;
        e_bt = 0;
        e_ct = 0;
        if (strobe && !m_high)
            tap_m = (DW - 1 - int'(speed_sel)) > 0 ? DW - 1 - int'(speed_sel) : 0;
        if (!m_halt) begin
            if (!m_high) begin
                if (hlt) m_halt = 1;
                else if (strobe && (!step_mode || m_pend)) begin
                    m_high = 1; e_bt = 1; m_pend = 0;
                end else m_pend = step_mode && (m_pend || m_press);
            end else if (strobe) begin
                e_ct = 1; m_high = 0;
                if (m_hreq || hlt) m_halt = 1;
                m_hreq = 0;
            end else m_hreq = m_hreq || hlt;
        end
        // Button is seen two edges late; it flips once 2^DB consecutive samples disagree with the stable level
        hist.push_back(step_btn);
        all_diff = 1;
        for (int i = 2; i < NDB + 2; i++)
            if (hist[hist.size() - 1 - i] == m_db) all_diff = 0;
        m_press = 0;
        if (all_diff) begin
            m_db = !m_db;
            m_press = m_db;
        end
        if (hist.size() > 64) void'(hist.pop_front());
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("bus_tick", bus_tick, e_bt);
        check("control_tick", control_tick, e_ct);
        check("bus_level", bus_level, m_high);
        check("halted", halted, m_halt);
        check("tick_exclusive", bus_tick & control_tick, 1'b0);
    endtask

    task automatic wait_high();
        for (int i = 0; i < 64 && !m_high; i++) cycle();
        check("wait_high_timeout", bus_level, 1'b1);
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_bus_tick", bus_tick, 1'b0);
        check("rst_control_tick", control_tick, 1'b0);
        check("rst_bus_level", bus_level, 1'b0);
        check("rst_halted", halted, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int len, gap;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_bus_tick", bus_tick, 1'b0);
        check("reset_control_tick", control_tick, 1'b0);
        check("reset_bus_level", bus_level, 1'b0);
        check("reset_halted", halted, 1'b0);
        rst = 1'b0;

        repeat (40) cycle();
        wait_high();
        speed_sel = 2'd3;
        repeat (30) cycle();

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) speed_sel = SB'($urandom);
            cycle();
        end

        step_mode = 1'b1;
        speed_sel = 2'd3;
        step_btn = 1'b1; repeat (6) cycle();
        step_btn = 1'b0; repeat (20) cycle();
        step_btn = 1'b1; repeat (2) cycle();
        step_btn = 1'b0; repeat (20) cycle();
        for (int i = 0; i < 80; i++) begin
            len = $urandom_range(1, 10);
            gap = $urandom_range(0, 20);
            if ($urandom_range(0, 3) == 0) speed_sel = SB'($urandom);
            step_btn = 1'b1; repeat (len) cycle();
            step_btn = 1'b0; repeat (gap) cycle();
        end
        repeat (10) cycle();

        step_mode = 1'b0;
        speed_sel = 2'd0;
        repeat (20) cycle();
        wait_high();
        hlt = 1'b1; repeat (20) cycle();
        hlt = 1'b0; repeat (100) cycle();

        async_reset();
        repeat (40) cycle();
        wait_high();
        repeat (3) cycle();
        async_reset();
        repeat (40) cycle();

        for (int r = 0; r < 4; r++) begin
            async_reset();
            for (int i = 0; i < 150; i++) begin
                if ($urandom_range(0, 15) == 0) speed_sel = SB'($urandom);
                if ($urandom_range(0, 31) == 0) step_mode = ~step_mode;
                step_btn = $urandom_range(0, 7) < 3;
                hlt = $urandom_range(0, 59) == 0;
                cycle();
            end
            hlt = 1'b0;
            step_btn = 1'b0;
            repeat (4) cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
